// File: rtl/signed_div_seq.sv
// Sequencer and sign-handling shell around an unsigned iterative divider.
// Launches the divider with operand magnitudes, times its fixed latency and fixes up signs.
module signed_div_seq #(
    parameter int DWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DWIDTH-1:0]   in_a,
    input  logic [DWIDTH-1:0]   in_b,
    input  logic                in_signed,
    output logic                div_start,
    output logic [DWIDTH-1:0]   div_x,
    output logic [DWIDTH-1:0]   div_y,
    input  logic [2*DWIDTH-1:0] div_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   out_q,
    output logic [DWIDTH-1:0]   out_r,
    output logic                out_dbz,
    output logic                out_ovf
);

    localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] MIN_VAL  = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX, S_HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;

    logic            accept, is_dbz, is_ovf;
    logic [DWIDTH-1:0] mag_a, mag_b, div_q, div_r;

    assign accept = in_valid && in_ready;
    assign is_dbz = (in_b == '0);
    assign is_ovf = in_signed && (in_a == MIN_VAL) && (in_b == '1);
    // MIN negates to itself, which is already the correct unsigned magnitude.
    assign mag_a  = (in_signed && in_a[DWIDTH-1]) ? -in_a : in_a;
    assign mag_b  = (in_signed && in_b[DWIDTH-1]) ? -in_b : in_b;
    assign div_q  = div_dout[2*DWIDTH-1:DWIDTH];
    assign div_r  = div_dout[DWIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = (is_dbz || is_ovf) ? S_HOLD : S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:    state_nxt = S_HOLD;
            S_HOLD:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        div_start = (state == S_LAUNCH);
        out_valid = (state == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div_x   <= '0;
            div_y   <= '0;
            out_q   <= '0;
            out_r   <= '0;
            out_dbz <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    neg_q <= in_signed && (in_a[DWIDTH-1] ^ in_b[DWIDTH-1]);
                    neg_r <= in_signed && in_a[DWIDTH-1];
                    if (is_dbz) begin
                        out_q   <= '1;
                        out_r   <= in_a;
                        out_dbz <= 1'b1;
                        out_ovf <= 1'b0;
                    end else if (is_ovf) begin
                        out_q   <= in_a;
                        out_r   <= '0;
                        out_dbz <= 1'b0;
                        out_ovf <= 1'b1;
                    end else begin
                        div_x <= mag_a;
                        div_y <= mag_b;
                    end
                end
                S_LAUNCH: cnt <= '0;
                S_WAIT:   cnt <= cnt + 1'b1;
                S_FIX: begin
                    out_q   <= neg_q ? -div_q : div_q;
                    out_r   <= neg_r ? -div_r : div_r;
                    out_dbz <= 1'b0;
                    out_ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_seq.sv
// Bench for signed_div_seq with a behavioural divider attached; results are checked
// against a plain-arithmetic reference of signed/unsigned division and its exceptions.
module tb_signed_div_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          in_signed = 1'b0;
    logic          div_start;
    logic [DW-1:0] div_x, div_y;
    logic [2*DW-1:0] div_dout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_q, out_r;
    logic          out_dbz, out_ovf;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int dcnt = 0;

    signed_div_seq #(.DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .div_start(div_start), .div_x(div_x), .div_y(div_y), .div_dout(div_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Divider model: garbage while busy, {q,r} written DW edges after start is sampled.
    always @(posedge clk) begin
        if (div_start) begin
            start_cnt <= start_cnt + 1;
            dcnt      <= DW;
            div_dout  <= 16'($urandom);
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) div_dout <= {div_x / div_y, div_x % div_y};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {dbz, ovf, q, r}.
    function automatic logic [2*DW+1:0] ref_div(input logic [DW-1:0] a, b, input logic s);
        int sa, sb;
        logic [DW-1:0] q, r;
        if (b == 0) return {1'b1, 1'b0, 8'hFF, a};
        if (s && a == 8'h80 && b == 8'hFF) return {1'b0, 1'b1, a, 8'h00};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {2'b00, q, r};
    endfunction

    task automatic do_op(input logic [DW-1:0] a, b, input logic s, input int hold);
        logic [2*DW+1:0] e;
        int lat, s0;
        bit exc;
        e   = ref_div(a, b, s);
        exc = e[2*DW+1] || e[2*DW];
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        s0 = start_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("latency", lat, exc ? 1 : DW + 2);
        chk("out_q", out_q, e[2*DW-1:DW]);
        chk("out_r", out_r, e[DW-1:0]);
        chk("out_dbz", out_dbz, e[2*DW+1]);
        chk("out_ovf", out_ovf, e[2*DW]);
        chk("div_start_pulses", start_cnt - s0, exc ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_q", out_q, e[2*DW-1:DW]);
            chk("hold_r", out_r, e[DW-1:0]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_after_handshake", out_valid, 0);
        chk("ready_after_handshake", in_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_div_start", div_start, 0);
        chk("reset_out_q", out_q, 0);
        chk("reset_out_r", out_r, 0);
        chk("reset_div_x", div_x, 0);

        do_op(8'd200, 8'd7, 1'b0, 0);
        do_op(8'hF9, 8'h02, 1'b1, 0);
        do_op(8'h07, 8'hFE, 1'b1, 0);
        do_op(8'hF9, 8'hFE, 1'b1, 0);
        do_op(8'h2A, 8'h00, 1'b0, 0);
        do_op(8'h2A, 8'h00, 1'b1, 0);
        do_op(8'h80, 8'hFF, 1'b1, 0);
        do_op(8'h80, 8'hFF, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b1, 0);
        do_op(8'h80, 8'h02, 1'b1, 0);
        do_op(8'd15, 8'd5, 1'b0, 5);
        do_op(8'd100, 8'd3, 1'b0, 0);

        // Abort a divide in flight.
        @(negedge clk);
        in_a = 8'd200; in_b = 8'd7; in_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_q", out_q, 0);
        do_op(8'd9, 8'd4, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 8'h00;
                1: begin ra = 8'h80; rb = 8'hFF; end
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
